// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and small decode helpers for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] RSH = 4'h1;
  localparam logic [3:0] LSH = 4'h2;
  localparam logic [3:0] NOT = 4'h3;
  localparam logic [3:0] AND = 4'h4;
  localparam logic [3:0] OR  = 4'h5;
  localparam logic [3:0] XOR = 4'h6;
  localparam logic [3:0] CMP = 4'h7;
  localparam logic [3:0] MUL = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Ops whose carry/shift-out is captured into the CF register.
  function automatic logic op_loads_cf(input logic [3:0] op);
    return (op == ADD) || (op == RSH) || (op == LSH);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of alu_seq, plus the FSM state as a debug observation point.
interface alu_seq_if #(parameter int WIDTH = 8);
  import alu_pkg::*;

  // Handshake: a transfer occurs on a rising edge where valid && ready are both high.
  // The producer holds its payload stable while valid is high and ready is low;
  // valid never depends combinationally on ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             use_cf;
  logic [3:0]       op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             c_out;
  logic             a_larger;
  logic             equal;
  logic             zero;
  logic             cf;

  alu_state_t       state;

  modport master (
    output in_valid, A, B, c_in, use_cf, op, out_ready,
    input  in_ready, out_valid, C, c_out, a_larger, equal, zero, cf, state
  );

  modport slave (
    input  in_valid, A, B, c_in, use_cf, op, out_ready,
    output in_ready, out_valid, C, c_out, a_larger, equal, zero, cf, state
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one product bit per clock.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic [WIDTH:0]     sum;

  // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand <= A;
        acc   <= {{WIDTH{1'b0}}, B};
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        acc <= {sum, acc[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod_lo = acc[WIDTH-1:0];
  assign prod_hi = acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and carry-flag register.
// Define ALU_MUL_EN to make op 8 a multi-cycle unsigned multiply; otherwise op 8 is reserved.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  alu_state_t       state, next_state;
  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic             ci;
  logic             cf_q;
  logic [WIDTH-1:0] core_c;
  logic             core_co;
  logic             mul_done;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] c_q;
  logic             c_out_q;
  logic             a_larger_q;
  logic             equal_q;
  logic             zero_q;

  assign ci = bus.use_cf ? cf_q : bus.c_in;

`ifdef ALU_MUL_EN
  assign is_mul = (bus.op == MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .A       (bus.A),
    .B       (bus.B),
    .done    (mul_done),
    .prod_lo (prod_lo),
    .prod_hi (prod_hi)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign prod_lo  = '0;
  assign prod_hi  = '0;
`endif

  // Single-cycle core; any op not listed (reserved extended ops) yields zero.
  always_comb begin
    core_c  = '0;
    core_co = 1'b0;
    case (bus.op)
      ADD: {core_co, core_c} = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, ci};
      RSH: begin
        core_c  = {ci, bus.A[WIDTH-1:1]};
        core_co = bus.A[0];
      end
      LSH: begin
        core_c  = {bus.A[WIDTH-2:0], ci};
        core_co = bus.A[WIDTH-1];
      end
      NOT:     core_c = ~bus.A;
      AND:     core_c = bus.A & bus.B;
      OR:      core_c = bus.A | bus.B;
      XOR:     core_c = bus.A ^ bus.B;
      CMP:     core_c = bus.A ^ bus.B;
      default: core_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: if (mul_done) next_state = DONE;
      DONE: if (bus.out_ready) begin
        in_ready   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    accept = bus.in_valid && in_ready;
    if (accept) next_state = is_mul ? BUSY : DONE;
  end

  // Comparison flags come from the accepted operands even for a multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q        <= '0;
      c_out_q    <= 1'b0;
      a_larger_q <= 1'b0;
      equal_q    <= 1'b0;
      zero_q     <= 1'b0;
      cf_q       <= 1'b0;
    end else begin
      if (accept) begin
        a_larger_q <= (bus.A > bus.B);
        equal_q    <= (bus.A == bus.B);
      end
      if (accept && !is_mul) begin
        c_q     <= core_c;
        c_out_q <= core_co;
        zero_q  <= (core_c == '0);
        if (op_loads_cf(bus.op)) cf_q <= core_co;
      end else if (state == BUSY && mul_done) begin
        c_q     <= prod_lo;
        c_out_q <= |prod_hi;
        zero_q  <= (prod_lo == '0);
        cf_q    <= |prod_hi;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.C         = c_q;
  assign bus.c_out     = c_out_q;
  assign bus.a_larger  = a_larger_q;
  assign bus.equal     = equal_q;
  assign bus.zero      = zero_q;
  assign bus.cf        = cf_q;
  assign bus.state     = state;

endmodule
